// File: rtl/e_mem_pkg.sv
// Shared constants and state type for the e_mem write side and its address generator.
// The address generator uses the same hold and ring constants.
package e_mem_pkg;

  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned HOLD_ADDR = 2048;
  localparam int unsigned WRAP_FROM = 262143;
  localparam int unsigned WRAP_TO   = 259072;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    HOLD,
    BODY,
    RING
  } state_t;

endpackage

// File: rtl/e_mem_wr_ptr.sv
// Shadow write pointer. It steps once per accepted word, and WRAP_FROM wraps to WRAP_TO.
// The read side is expected to reuse this module.
module e_mem_wr_ptr #(
  parameter int unsigned ADDR_W    = e_mem_pkg::ADDR_W,
  parameter int unsigned WRAP_FROM = e_mem_pkg::WRAP_FROM,
  parameter int unsigned WRAP_TO   = e_mem_pkg::WRAP_TO
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] ptr
);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (step) begin
      if (ptr == ADDR_W'(WRAP_FROM)) begin
        ptr <= ADDR_W'(WRAP_TO);
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/e_mem_fill_ctrl.sv
// Write-side sequencer for the e_mem address generator and BRAM.
// The release pulse is carried on hold_release, because 'release' is a reserved word.
module e_mem_fill_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = e_mem_pkg::ADDR_W,
  parameter int unsigned HOLD_ADDR = e_mem_pkg::HOLD_ADDR,
  parameter int unsigned WRAP_FROM = e_mem_pkg::WRAP_FROM,
  parameter int unsigned WRAP_TO   = e_mem_pkg::WRAP_TO
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              hold_release,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              e_mem_addr_en,
  output logic              stall,
  output logic              addr_clr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              head_done,
  output logic              wrapped,
  output logic              busy
);

  import e_mem_pkg::*;

  state_t state;
  logic   xfer;
  logic   ptr_clr;
  logic   at_head_end;
  logic   at_wrap_from;

  assign s_ready      = (state == HEAD) || (state == BODY) || (state == RING);
  assign busy         = (state != IDLE);
  assign xfer         = s_valid && s_ready;
  assign ptr_clr      = (state == IDLE) && start;
  assign at_head_end  = (wr_ptr == ADDR_W'(HOLD_ADDR - 1));
  assign at_wrap_from = (wr_ptr == ADDR_W'(WRAP_FROM));

  e_mem_wr_ptr #(
    .ADDR_W   (ADDR_W),
    .WRAP_FROM(WRAP_FROM),
    .WRAP_TO  (WRAP_TO)
  ) u_wr_ptr (
    .CLK  (CLK),
    .rst  (rst),
    .clear(ptr_clr),
    .step (xfer),
    .ptr  (wr_ptr)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      e_mem_addr_en <= 1'b0;
      stall         <= 1'b0;
      addr_clr      <= 1'b0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      head_done     <= 1'b0;
      wrapped       <= 1'b0;
    end else begin
      // A word accepted on the same edge as stop is still written.
      mem_we        <= xfer;
      e_mem_addr_en <= xfer;
      addr_clr      <= 1'b0;
      if (xfer) begin
        mem_wdata <= s_data;
      end
      if ((state == HEAD) && xfer && at_head_end) begin
        head_done <= 1'b1;
      end
      if ((state == BODY) && xfer && at_wrap_from) begin
        wrapped <= 1'b1;
      end

      if ((state != IDLE) && stop) begin
        state <= IDLE;
        stall <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= HEAD;
              addr_clr  <= 1'b1;
              head_done <= 1'b0;
              wrapped   <= 1'b0;
            end
          end
          HEAD: begin
            if (xfer && at_head_end) begin
              state <= HOLD;
            end
          end
          HOLD: begin
            // Stall waits one cycle so the last head enable can move the generator to HOLD_ADDR.
            if (hold_release) begin
              state <= BODY;
              stall <= 1'b0;
            end else begin
              stall <= 1'b1;
            end
          end
          BODY: begin
            if (xfer && at_wrap_from) begin
              state <= RING;
            end
          end
          RING: begin
            state <= RING;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_e_mem_fill_ctrl.sv
// Bench for e_mem_fill_ctrl: one full-size instance, plus one with a small ring for tables and random streams.
// Each instance has a model of the address generator and the BRAM.
module tb_e_mem_fill_ctrl;

  localparam int unsigned BDW   = 16;
  localparam int unsigned BAW   = 12;
  localparam int unsigned BHOLD = 4;
  localparam int unsigned BFROM = 4095;
  localparam int unsigned BTO   = 4064;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic        start_a, stop_a, rel_a, sv_a;
  logic [31:0] sd_a;
  logic        rdy_a, en_a, stall_a, clr_a, we_a, head_a, wrap_a, busy_a;
  logic [31:0] wd_a;
  logic [17:0] ptr_a;

  logic           start_b, stop_b, rel_b, sv_b;
  logic [BDW-1:0] sd_b;
  logic           rdy_b, en_b, stall_b, clr_b, we_b, head_b, wrap_b, busy_b;
  logic [BDW-1:0] wd_b;
  logic [BAW-1:0] ptr_b;

  e_mem_fill_ctrl dut_a (
    .CLK(CLK), .rst(rst), .start(start_a), .stop(stop_a), .hold_release(rel_a),
    .s_valid(sv_a), .s_data(sd_a), .s_ready(rdy_a), .e_mem_addr_en(en_a),
    .stall(stall_a), .addr_clr(clr_a), .mem_we(we_a), .mem_wdata(wd_a),
    .wr_ptr(ptr_a), .head_done(head_a), .wrapped(wrap_a), .busy(busy_a)
  );

  e_mem_fill_ctrl #(
    .DATA_W(BDW), .ADDR_W(BAW), .HOLD_ADDR(BHOLD), .WRAP_FROM(BFROM), .WRAP_TO(BTO)
  ) dut_b (
    .CLK(CLK), .rst(rst), .start(start_b), .stop(stop_b), .hold_release(rel_b),
    .s_valid(sv_b), .s_data(sd_b), .s_ready(rdy_b), .e_mem_addr_en(en_b),
    .stall(stall_b), .addr_clr(clr_b), .mem_we(we_b), .mem_wdata(wd_b),
    .wr_ptr(ptr_b), .head_done(head_b), .wrapped(wrap_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Address sequence for the small ring: 0,1,..,BFROM, then BTO..BFROM repeating.
  function automatic int unsigned ring_addr(input int unsigned n);
    if (n <= BFROM) return n;
    return BTO + (n - BTO) % (BFROM - BTO + 1);
  endfunction

  // Generator and BRAM model for instance A.
  logic [31:0] bram_a [int];
  int unsigned gen_a;
  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      gen_a = 0;
    end else begin
      if (we_a) bram_a[int'(gen_a)] = wd_a;
      if (clr_a) gen_a = 0;
      else if (en_a && !stall_a)
        gen_a = (gen_a == e_mem_pkg::WRAP_FROM) ? e_mem_pkg::WRAP_TO : gen_a + 1;
    end
  end

  function automatic logic [31:0] rd_a(input int idx);
    if (bram_a.exists(idx)) return bram_a[idx];
    return 32'hxxxxxxxx;
  endfunction

  // Generator model and write scoreboard for instance B.
  typedef struct {
    int unsigned    addr;
    logic [BDW-1:0] data;
  } wr_t;
  wr_t         sb_q[$];
  wr_t         sb_w;
  int unsigned ref_n;
  int unsigned gen_b;
  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      gen_b = 0;
      ref_n = 0;
      sb_q.delete();
    end else begin
      if (we_b) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_write_pending actual=none required=queued word");
        end else begin
          sb_w = sb_q.pop_front();
          chk("b_wr_addr", gen_b, sb_w.addr);
          chk("b_wr_data", 32'(wd_b), 32'(sb_w.data));
        end
      end
      if (sv_b && rdy_b) begin
        sb_q.push_back('{ring_addr(ref_n), sd_b});
        ref_n++;
      end
      if (start_b && !busy_b) ref_n = 0;
      if (clr_b) gen_b = 0;
      else if (en_b && !stall_b) gen_b = (gen_b == BFROM) ? BTO : gen_b + 1;
    end
  end

  always @(negedge CLK) begin
    if (!rst) begin
      if (busy_a && !we_a && !clr_a) chk("a_ptr_vs_gen", 32'(ptr_a), gen_a);
      if (busy_b && !we_b && !clr_b) chk("b_ptr_vs_gen", 32'(ptr_b), gen_b);
      if (busy_b) chk("b_ptr_vs_ref", 32'(ptr_b), ring_addr(ref_n));
      if (en_a) chk("a_en_while_stall", 32'(stall_a), 0);
    end
  end

  typedef struct {
    logic           start, stop, rel, sv;
    logic [BDW-1:0] sd;
    logic [6:0]     flags;  // {rdy, busy, stall, clr, we, head_done, wrapped}
    logic [BAW-1:0] ptr;
    logic [BDW-1:0] wd;
  } vec_t;
  vec_t tbl [16];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int cyc;
    int hold_wait;
    bit released;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b1101000, 12'd0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 7'b1100100, 12'd1, 16'h0011};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0022, 7'b1100100, 12'd2, 16'h0022};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b1100000, 12'd2, 16'h0000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0033, 7'b1100100, 12'd3, 16'h0033};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0044, 7'b0100110, 12'd4, 16'h0044};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0055, 7'b0110010, 12'd4, 16'h0000};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b0110010, 12'd4, 16'h0000};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 7'b1100010, 12'd4, 16'h0000};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0066, 7'b1100110, 12'd5, 16'h0066};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b1100010, 12'd5, 16'h0000};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0077, 7'b0000110, 12'd6, 16'h0077};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b0000010, 12'd6, 16'h0000};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b0000010, 12'd6, 16'h0000};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b1101000, 12'd0, 16'h0000};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b0000000, 12'd0, 16'h0000};

    {start_a, stop_a, rel_a, sv_a} = '0;
    sd_a = '0;
    {start_b, stop_b, rel_b, sv_b} = '0;
    sd_b = '0;
    rst = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_flags_a", 32'({rdy_a, en_a, stall_a, clr_a, we_a, head_a, wrap_a, busy_a}), 0);
    chk("rst_ptr_a", 32'(ptr_a), 0);
    chk("rst_wdata_a", wd_a, 0);
    rst = 1'b0;
    tick();

    // Fill the 2048-word head, then hold.
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("start_clr", 32'(clr_a), 1);
    chk("start_busy", 32'(busy_a), 1);
    for (int i = 0; i < 2048; i++) begin
      sv_a = 1'b1; sd_a = 32'(i); tick();
    end
    sv_a = 1'b0;
    chk("head_done", 32'(head_a), 1);
    chk("hold_ready", 32'(rdy_a), 0);
    chk("final_head_we", 32'(we_a), 1);
    tick();
    chk("hold_stall", 32'(stall_a), 1);
    chk("gen_parked", gen_a, 2048);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (we_a || en_a || rdy_a || !stall_a || gen_a != 2048) bad++;
      tick();
    end
    chk("hold_20_quiet", 32'(bad), 0);
    bad = 0;
    for (int i = 0; i < 2048; i++) if (rd_a(i) !== 32'(i)) bad++;
    chk("head_bram", 32'(bad), 0);
    chk("no_write_2048", 32'(bram_a.exists(2048)), 0);

    rel_a = 1'b1; tick(); rel_a = 1'b0;
    chk("release_stall", 32'(stall_a), 0);
    chk("release_ready", 32'(rdy_a), 1);
    sv_a = 1'b1; sd_a = 32'hABCD; tick(); sv_a = 1'b0;
    chk("body_ptr", 32'(ptr_a), 2049);
    tick();
    chk("body_word_2048", rd_a(2048), 32'hABCD);
    rel_a = 1'b1; tick(); rel_a = 1'b0;
    chk("body_rel_ignored", 32'({busy_a, rdy_a, stall_a}), 32'b110);

    // Asynchronous reset in the middle of BODY.
    @(posedge CLK);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", 32'({rdy_a, en_a, stall_a, clr_a, we_a, head_a, wrap_a, busy_a}), 0);
    chk("async_rst_ptr", 32'(ptr_a), 0);
    chk("async_rst_wdata", wd_a, 0);
    tick();
    rst = 1'b0;
    tick();

    // Stop together with a transfer at wr_ptr 100, then refill.
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("restart_clr", 32'(clr_a), 1);
    for (int i = 0; i < 100; i++) begin
      sv_a = 1'b1; sd_a = 32'h1000 + 32'(i); tick();
    end
    chk("pre_stop_ptr", 32'(ptr_a), 100);
    sd_a = 32'hDEAD; stop_a = 1'b1; tick(); stop_a = 1'b0; sv_a = 1'b0;
    chk("stop_idle", 32'({busy_a, rdy_a, stall_a}), 0);
    chk("stop_write_issued", 32'(we_a), 1);
    chk("stop_ptr", 32'(ptr_a), 101);
    tick();
    chk("stop_word_at_100", rd_a(100), 32'hDEAD);
    chk("stop_no_more_we", 32'(we_a), 0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("refill_clr", 32'(clr_a), 1);
    chk("refill_ptr", 32'(ptr_a), 0);
    tick();
    chk("refill_clr_one_cycle", 32'(clr_a), 0);
    chk("refill_gen_zero", gen_a, 0);
    sv_a = 1'b1; sd_a = 32'h5555; tick(); sv_a = 1'b0;
    tick();
    chk("refill_word0", rd_a(0), 32'h5555);
    start_a = 1'b1; stop_a = 1'b1; tick(); start_a = 1'b0; stop_a = 1'b0;
    chk("start_stop_idle", 32'(busy_a), 0);
    chk("start_stop_no_clr", 32'(clr_a), 0);

    // Small-ring instance: vector table.
    for (int i = 0; i < 16; i++) begin
      start_b = tbl[i].start; stop_b = tbl[i].stop; rel_b = tbl[i].rel;
      sv_b = tbl[i].sv; sd_b = tbl[i].sd;
      tick();
      chk($sformatf("vec%0d_flags", i),
          32'({rdy_b, busy_b, stall_b, clr_b, we_b, head_b, wrap_b}), 32'(tbl[i].flags));
      chk($sformatf("vec%0d_ptr", i), 32'(ptr_b), 32'(tbl[i].ptr));
      if (tbl[i].flags[2]) chk($sformatf("vec%0d_wdata", i), 32'(wd_b), 32'(tbl[i].wd));
    end
    {start_b, stop_b, rel_b, sv_b} = '0;
    tick();

    // Small-ring instance: random stream through head, hold and several ring wraps.
    start_b = 1'b1; tick(); start_b = 1'b0;
    cyc = 0;
    released = 1'b0;
    hold_wait = $urandom_range(1, 20);
    while (ref_n < 4200 && cyc < 12000) begin
      sv_b = ($urandom_range(0, 3) != 0);
      sd_b = BDW'($urandom);
      rel_b = 1'b0;
      if (busy_b && !rdy_b && head_b && !released) begin
        if (hold_wait == 0) begin
          rel_b = 1'b1;
          released = 1'b1;
        end else begin
          hold_wait--;
        end
      end
      tick();
      cyc++;
    end
    sv_b = 1'b0;
    rel_b = 1'b0;
    chk("rand_budget", 32'(cyc < 12000), 1);
    tick();
    tick();
    chk("rand_wrapped", 32'(wrap_b), 1);
    chk("rand_queue_drained", 32'(sb_q.size()), 0);
    chk("rand_ptr", 32'(ptr_b), ring_addr(ref_n));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mem_fill_ctrl.md
Name: e_mem_fill_ctrl

Overview:
Write-side sequencer that feeds the e_mem address generator and its BRAM.
- Accepts a valid/ready data stream and issues registered write strobes and data.
- Drives the generator's e_mem_addr_en, stall and synchronous clear.
- Keeps a shadow write pointer that follows the generator's hold-at-2048 rule and its 262143->259072 ring rule, so every write lands where intended.

Parameters:
DATA_W, 32, stream/BRAM data width
ADDR_W, 18, BRAM address width
HOLD_ADDR, 2048, first address of the body region; writing pauses here until release
WRAP_FROM, 262143, last BRAM address
WRAP_TO, 259072, ring restart address

Ports:
CLK  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  pulse; begins a fill from address 0
stop  in  1  pulse; aborts the fill
release  in  1  pulse; ends the hold at HOLD_ADDR
s_valid  in  1  stream data valid
s_data  in  DATA_W  stream data
s_ready  out  1  stream ready
e_mem_addr_en  out  1  address generator increment enable
stall  out  1  address generator hold request
addr_clr  out  1  one-cycle synchronous clear to the address generator
mem_we  out  1  BRAM write enable
mem_wdata  out  DATA_W  BRAM write data
wr_ptr  out  ADDR_W  shadow of the next address the generator will present
head_done  out  1  high once addresses 0..HOLD_ADDR-1 have been accepted
wrapped  out  1  sticky; ring region entered
busy  out  1  state is not IDLE

Behaviour:
- Reset values (on rst, asynchronously): state IDLE, wr_ptr=0, and all outputs 0 (s_ready, e_mem_addr_en, stall, addr_clr, mem_we, mem_wdata, head_done, wrapped, busy).
- States: IDLE, HEAD, HOLD, BODY, RING.
- s_ready is a pure decode of state: high in HEAD, BODY and RING.
- Transfer occurs when s_valid && s_ready.
- Write-path latency is 1 cycle. In the cycle after a transfer:
  - mem_we=1, e_mem_addr_en=1, mem_wdata=the captured s_data.
  - The BRAM writes at the generator's current address on that edge, and the generator advances on the same edge.
  - With no transfer, mem_we=0 and e_mem_addr_en=0; mem_wdata holds its last value.
- wr_ptr updates on each transfer: WRAP_FROM goes to WRAP_TO; every other value increments.
- IDLE:
  - start -> registered addr_clr=1 for one cycle, wr_ptr=0, head_done=0, wrapped=0, then HEAD.
  - stop is ignored in IDLE.
- HEAD: a transfer with wr_ptr==HOLD_ADDR-1 moves the block to HOLD and sets head_done.
- HOLD:
  - stall=1, s_ready=0, e_mem_addr_en=0 once the final head write has retired.
  - That final write's enable reaches the generator while it still shows 2047, so it advances to 2048 and then holds.
  - release (sampled only in HOLD) -> BODY, with stall=0 from the next cycle.
- BODY: a transfer with wr_ptr==WRAP_FROM -> RING, wr_ptr=WRAP_TO, wrapped=1.
- RING: writes continue indefinitely; each wrap from WRAP_FROM goes to WRAP_TO.
- stop in HEAD, HOLD, BODY or RING -> IDLE on the next edge:
  - s_ready falls.
  - A write registered on that edge still issues.
  - stall clears.
  - head_done and wrapped keep their values until the next start.
- Priority: stop beats start and release in the same cycle; start in a non-IDLE state is ignored.
- A transfer and stop in the same cycle: the transfer is accepted and written, then the block goes to IDLE.
- Assertion (bench): wr_ptr equals the generator's mem_address whenever mem_we=0 and state!=IDLE.

Decomposition:
- Package e_mem_pkg: HOLD_ADDR, WRAP_FROM and WRAP_TO constants, the ADDR_W localparam, and the state enum (IDLE/HEAD/HOLD/BODY/RING). The address generator shares these constants.
- One sub-module, e_mem_wr_ptr: the shadow pointer. It takes clear, step and clock/reset and implements the wrap rule. It is reusable by the future read side.

Test Plan:
- rst mid-BODY -> all outputs 0 immediately with no clock needed; state IDLE; wr_ptr=0.
- start, then 2048 back-to-back words (data=index) -> BRAM[0..2047]=0..2047; head_done=1; stall=1; s_ready=0; generator parked at 2048; no write occurs at 2048 during a 20-cycle hold.
- release during HOLD, then one word 0xABCD -> written at 2048; wr_ptr=2049; stall=0.
- Preload the generator and shadow near the end, then stream 3 words at addresses 262142/262143 -> third word written at 259072; wrapped=1; wr_ptr=259073.
- stop asserted with a transfer in the same cycle at wr_ptr=100 -> word written at 100; IDLE next cycle; a later start pulses addr_clr and refills from 0.
- start and stop in the same cycle while in HEAD -> IDLE; no addr_clr; release pulse in BODY -> ignored.
